// File: rtl/crc8_serial_checker.sv
// Serial CRC-8 receive checker: runs the frame through the transmitter's LFSR and compares the appended CRC.
// Latency: done pulses on the edge after the one that samples the last CRC bit, or after a timeout or abort.
// Backpressure: none; the serial stream is consumed every cycle, and CRC gaps are tolerated up to TIMEOUT.
module crc8_serial_checker #(
    parameter logic [7:0]  SEED    = 8'hD8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_in,
    input  logic       data_active,
    input  logic       crc_in,
    input  logic       crc_valid,
    output logic       busy,
    output logic       done,
    output logic       crc_ok,
    output logic [1:0] status,
    output logic [7:0] rx_crc,
    output logic [7:0] calc_crc
);

    typedef enum logic [1:0] {IDLE, DATA, CRC, CHECK} state_t;

    localparam logic [7:0] IDLE_LIMIT = 8'(TIMEOUT - 1);
    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_BAD     = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_ABORT   = 2'b11;

    state_t     state, state_nxt;
    logic [7:0] lfsr, lfsr_step;
    logic [7:0] rx_sr;
    logic [2:0] bit_cnt;
    logic [7:0] idle_cnt;
    logic [1:0] pend, pend_nxt;
    logic       fb;
    logic       match;

    assign fb        = data_in ^ lfsr[0];
    assign lfsr_step = {fb, lfsr[7] ^ fb, lfsr[6], lfsr[5], lfsr[4], lfsr[3] ^ fb, lfsr[2], lfsr[1]};
    assign match     = (rx_sr == lfsr);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            pend  <= ST_OK;
        end else begin
            state <= state_nxt;
            pend  <= pend_nxt;
        end
    end

    // pend carries a timeout/abort verdict from CRC into CHECK; ST_OK means none.
    always_comb begin
        state_nxt = state;
        pend_nxt  = pend;
        case (state)
            IDLE: begin
                if (data_active) state_nxt = DATA;
            end
            DATA: begin
                if (!data_active) begin
                    state_nxt = CRC;
                    pend_nxt  = ST_OK;
                end
            end
            CRC: begin
                if (data_active) begin
                    state_nxt = CHECK;
                    pend_nxt  = ST_ABORT;
                end else if (crc_valid) begin
                    if (bit_cnt == 3'd7) state_nxt = CHECK;
                end else if (idle_cnt == IDLE_LIMIT) begin
                    state_nxt = CHECK;
                    pend_nxt  = ST_TIMEOUT;
                end
            end
            CHECK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr     <= SEED;
            rx_sr    <= '0;
            bit_cnt  <= '0;
            idle_cnt <= '0;
            done     <= 1'b0;
            crc_ok   <= 1'b0;
            status   <= ST_OK;
            rx_crc   <= '0;
            calc_crc <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (data_active) lfsr <= lfsr_step;
                end
                DATA: begin
                    if (data_active) begin
                        lfsr <= lfsr_step;
                    end else begin
                        bit_cnt  <= '0;
                        idle_cnt <= '0;
                        rx_sr    <= '0;
                    end
                end
                CRC: begin
                    if (!data_active) begin
                        if (crc_valid) begin
                            rx_sr    <= {crc_in, rx_sr[7:1]};
                            bit_cnt  <= bit_cnt + 3'd1;
                            idle_cnt <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + 8'd1;
                        end
                    end
                end
                CHECK: begin
                    // Results are published together so the outputs stay coherent until the next done.
                    done     <= 1'b1;
                    calc_crc <= lfsr;
                    rx_crc   <= rx_sr;
                    crc_ok   <= (pend == ST_OK) && match;
                    status   <= (pend != ST_OK) ? pend : (match ? ST_OK : ST_BAD);
                    lfsr     <= SEED;
                end
                default: begin
                    lfsr <= SEED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc8_serial_checker.sv
// Directed bench for crc8_serial_checker; expected results are queued at stimulus time and popped on done.
module tb_crc8_serial_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       data_in = 1'b0;
    logic       data_active = 1'b0;
    logic       crc_in = 1'b0;
    logic       crc_valid = 1'b0;
    logic       busy, done, crc_ok;
    logic [1:0] status;
    logic [7:0] rx_crc, calc_crc;

    typedef struct packed {
        logic       ok;
        logic [1:0] st;
        logic [7:0] calc;
        logic [7:0] rx;
        logic       chk_rx;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    logic prev_done = 1'b0;

    always #5 clk = ~clk;

    crc8_serial_checker #(.SEED(8'hD8), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_active(data_active),
        .crc_in(crc_in), .crc_valid(crc_valid), .busy(busy), .done(done),
        .crc_ok(crc_ok), .status(status), .rx_crc(rx_crc), .calc_crc(calc_crc)
    );

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] step(input logic [7:0] s, input logic d);
        logic f;
        f = d ^ s[0];
        return {f, s[7] ^ f, s[6], s[5], s[4], s[3] ^ f, s[2], s[1]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs were driven at the previous negedge, outputs are sampled at this one.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        if (done === 1'b1) begin
            chk("done_pulse_width", 32'(prev_done), 32'd0);
            chk("done_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("crc_ok", 32'(crc_ok), 32'(e.ok));
                chk("status", 32'(status), 32'(e.st));
                chk("calc_crc", 32'(calc_crc), 32'(e.calc));
                if (e.chk_rx) chk("rx_crc", 32'(rx_crc), 32'(e.rx));
                chk("busy_at_done", 32'(busy), 32'd0);
            end
        end
        prev_done = done;
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        while (sb.size() != 0 && n < max) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            chk("done_wait", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic send_bits(input logic [31:0] bits, input int nb);
        for (int i = 0; i < nb; i++) begin
            data_active = 1'b1;
            data_in     = bits[i];
            tick();
        end
        data_active = 1'b0;
        data_in     = 1'b0;
        tick();
    endtask

    task automatic send_crc(input logic [7:0] c, input int nb, input int gap);
        for (int i = 0; i < nb; i++) begin
            crc_valid = 1'b1;
            crc_in    = c[i];
            tick();
            crc_valid = 1'b0;
            crc_in    = 1'b0;
            for (int g = 0; g < gap; g++) tick();
        end
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_busy"}, 32'(busy), 32'd0);
        chk({pfx, "_done"}, 32'(done), 32'd0);
        chk({pfx, "_crc_ok"}, 32'(crc_ok), 32'd0);
        chk({pfx, "_status"}, 32'(status), 32'd0);
        chk({pfx, "_rx_crc"}, 32'(rx_crc), 32'd0);
        chk({pfx, "_calc_crc"}, 32'(calc_crc), 32'd0);
    endtask

    initial begin
        int         n;
        logic [7:0] m;
        logic [31:0] frame;

        @(negedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b1;
        tick();

        // 1-bit frame of 0, matching CRC 0x6C, with an exact latency check.
        sb.push_back('{ok: 1'b1, st: 2'b00, calc: 8'h6C, rx: 8'h6C, chk_rx: 1'b1});
        send_bits(32'h0, 1);
        chk("busy_in_crc", 32'(busy), 32'd1);
        send_crc(8'h6C, 8, 0);
        chk("done_not_early", 32'(done), 32'd0);
        chk("busy_in_check", 32'(busy), 32'd1);
        wait_done(4, n);
        chk("latency_ok_frame", 32'(n), 32'd1);
        tick();

        // 1-bit frame of 1 expects 0xA8; 0x6C is sent instead.
        sb.push_back('{ok: 1'b0, st: 2'b01, calc: 8'hA8, rx: 8'h6C, chk_rx: 1'b1});
        send_bits(32'h1, 1);
        send_crc(8'h6C, 8, 0);
        wait_done(4, n);
        tick();

        // 2-bit frame 1,0 -> 0x54, CRC bits spaced by 3 idle cycles.
        sb.push_back('{ok: 1'b1, st: 2'b00, calc: 8'h54, rx: 8'h54, chk_rx: 1'b1});
        send_bits(32'h1, 2);
        send_crc(8'h54, 8, 3);
        wait_done(4, n);
        tick();

        // Timeout: 3 CRC bits, then crc_valid stays low.
        sb.push_back('{ok: 1'b0, st: 2'b10, calc: 8'h6C, rx: 8'h00, chk_rx: 1'b0});
        send_bits(32'h0, 1);
        send_crc(8'h6C, 3, 0);
        for (int i = 0; i < 15; i++) tick();
        chk("busy_during_gap", 32'(busy), 32'd1);
        chk("no_done_before_timeout", 32'(sb.size()), 32'd1);
        wait_done(6, n);
        chk("latency_timeout", 32'(n), 32'd2);
        tick();
        chk("busy_after_timeout", 32'(busy), 32'd0);

        // Abort: data_active re-asserted after 4 CRC bits, with crc_valid high in the same cycle.
        sb.push_back('{ok: 1'b0, st: 2'b11, calc: 8'h6C, rx: 8'h00, chk_rx: 1'b0});
        send_bits(32'h0, 1);
        send_crc(8'h6C, 4, 0);
        data_active = 1'b1;
        data_in     = 1'b1;
        crc_valid   = 1'b1;
        crc_in      = 1'b1;
        tick();
        data_active = 1'b0;
        data_in     = 1'b0;
        crc_valid   = 1'b0;
        crc_in      = 1'b0;
        wait_done(4, n);
        chk("latency_abort", 32'(n), 32'd1);
        tick();

        // Next frame after abort must start from a reseeded LFSR.
        sb.push_back('{ok: 1'b1, st: 2'b00, calc: 8'hA8, rx: 8'hA8, chk_rx: 1'b1});
        send_bits(32'h1, 1);
        send_crc(8'hA8, 8, 0);
        wait_done(4, n);
        tick();

        // Reset mid-CRC phase: outputs clear at once and no done follows.
        send_bits(32'h0, 1);
        send_crc(8'h6C, 4, 0);
        rst = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("midreset_busy", 32'(busy), 32'd0);

        sb.push_back('{ok: 1'b1, st: 2'b00, calc: 8'h6C, rx: 8'h6C, chk_rx: 1'b1});
        send_bits(32'h0, 1);
        send_crc(8'h6C, 8, 0);
        wait_done(4, n);
        tick();

        // Longer frame with the expected CRC from the bench's own LFSR model.
        frame = 32'h0000_00A5;
        m = 8'hD8;
        for (int i = 0; i < 8; i++) m = step(m, frame[i]);
        sb.push_back('{ok: 1'b1, st: 2'b00, calc: m, rx: m, chk_rx: 1'b1});
        send_bits(frame, 8);
        send_crc(m, 8, 1);
        wait_done(4, n);
        tick();

        // Same frame with one flipped CRC bit must mismatch.
        sb.push_back('{ok: 1'b0, st: 2'b01, calc: m, rx: m ^ 8'h10, chk_rx: 1'b1});
        send_bits(frame, 8);
        send_crc(m ^ 8'h10, 8, 0);
        wait_done(4, n);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
